// File: rtl/nbit_sqrt.sv
// Iterative integer square root: restoring two-bits-per-step digit recurrence.
// Accepts a 2N-bit radicand on start and returns floor root and remainder after N cycles.
module nbit_sqrt #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] radicand,
  output logic [N-1:0]   root,
  output logic [N:0]     remainder,
  output logic           busy,
  output logic           done
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

  state_t          state_r;
  logic [2*N-1:0]  x_r;
  logic [N+1:0]    r_r;
  logic [N-1:0]    q_r;
  logic [CW-1:0]   cnt_r;

  logic [N+1:0]    r_sh_s;
  logic [N+1:0]    trial_s;
  logic            ge_s;
  logic [N+1:0]    r_nxt_s;
  logic [N-1:0]    q_nxt_s;

  // One recurrence step: bring down the next radicand digit pair and try subtracting 4q+1.
  always_comb begin
    r_sh_s  = (r_r << 2) | {{N{1'b0}}, x_r[2*N-1 -: 2]};
    trial_s = ({2'b00, q_r} << 2) | {{N{1'b0}}, 2'b01};
    ge_s    = (r_sh_s >= trial_s);
    if (ge_s) begin
      r_nxt_s = r_sh_s - trial_s;
    end else begin
      r_nxt_s = r_sh_s;
    end
    q_nxt_s = {q_r[N-2:0], ge_s};
  end

  // Control FSM and datapath registers; results only move on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      x_r       <= {(2*N){1'b0}};
      r_r       <= {(N+2){1'b0}};
      q_r       <= {N{1'b0}};
      cnt_r     <= {CW{1'b0}};
      root      <= {N{1'b0}};
      remainder <= {(N+1){1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            x_r     <= radicand;
            r_r     <= {(N+2){1'b0}};
            q_r     <= {N{1'b0}};
            cnt_r   <= CW'(N - 1);
            busy    <= 1'b1;
            state_r <= ST_CALC;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_CALC: begin
          x_r <= x_r << 2;
          r_r <= r_nxt_s;
          q_r <= q_nxt_s;
          if (cnt_r == {CW{1'b0}}) begin
            // Top bit of the partial remainder is provably zero here.
            root      <= q_nxt_s;
            remainder <= r_nxt_s[N:0];
            done      <= 1'b1;
            busy      <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nbit_sqrt.sv
// Scoreboard bench for nbit_sqrt at N=8 and N=16, against a binary-search
// integer square root model.
module tb_nbit_sqrt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, start16;
  logic [15:0] rad8;
  logic [31:0] rad16;
  logic [7:0]  root8;
  logic [8:0]  rem8;
  logic        busy8, done8;
  logic [15:0] root16;
  logic [16:0] rem16;
  logic        busy16, done16;

  always #5 clk = ~clk;

  nbit_sqrt #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .radicand(rad8),
    .root(root8), .remainder(rem8), .busy(busy8), .done(done8)
  );

  nbit_sqrt #(.N(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .radicand(rad16),
    .root(root16), .remainder(rem16), .busy(busy16), .done(done16)
  );

  typedef struct {
    longint rad;
    longint root;
    longint rem;
    longint acc;
  } exp_t;

  exp_t   q8[$];
  exp_t   q16[$];
  exp_t   e8, e16;
  int     total = 0;
  int     bad = 0;
  longint edges = 0;

  always @(posedge clk) edges <= edges + 1;

  function automatic longint isqrt(input longint v);
    longint lo, hi, mid;
    lo = 0;
    hi = 65536;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input bit wide, input longint rad);
    int   t;
    exp_t e;
    t = 0;
    while ((wide ? busy16 : busy8) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("accept_timeout", (t >= 100) ? 1 : 0, 0);
    e.rad  = rad;
    e.root = isqrt(rad);
    e.rem  = rad - e.root * e.root;
    e.acc  = edges + 1;
    if (wide) begin
      start16 = 1'b1;
      rad16   = 32'(rad);
      q16.push_back(e);
    end else begin
      start8 = 1'b1;
      rad8   = 16'(rad);
      q8.push_back(e);
    end
    @(negedge clk);
    start8  = 1'b0;
    start16 = 1'b0;
    rad8    = 16'($urandom);
    rad16   = $urandom;
  endtask

  // Monitor for the N=8 instance.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", 1, 0);
      end else begin
        e8 = q8.pop_front();
        chk("root8", longint'(root8), e8.root);
        chk("rem8", longint'(rem8), e8.rem);
        chk("latency8", edges - e8.acc, 8);
        chk("identity8", longint'(root8) * longint'(root8) + longint'(rem8), e8.rad);
        chk("rem_bound8", (longint'(rem8) <= 2 * longint'(root8)) ? 1 : 0, 1);
      end
    end
  end

  // Monitor for the N=16 instance.
  always @(negedge clk) begin
    if (done16) begin
      if (q16.size() == 0) begin
        chk("unexpected_done16", 1, 0);
      end else begin
        e16 = q16.pop_front();
        chk("root16", longint'(root16), e16.root);
        chk("rem16", longint'(rem16), e16.rem);
        chk("latency16", edges - e16.acc, 16);
        chk("identity16", longint'(root16) * longint'(root16) + longint'(rem16), e16.rad);
        chk("rem_bound16", (longint'(rem16) <= 2 * longint'(root16)) ? 1 : 0, 1);
      end
    end
  end

  initial begin
    int n;
    longint v;
    rst_n   = 1'b0;
    start8  = 1'b0;
    start16 = 1'b0;
    rad8    = 16'd0;
    rad16   = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_root8", longint'(root8), 0);
    chk("reset_rem8", longint'(rem8), 0);
    chk("reset_busy8", longint'(busy8), 0);
    chk("reset_done8", longint'(done8), 0);
    chk("reset_root16", longint'(root16), 0);
    chk("reset_busy16", longint'(busy16), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Radicand 0 and busy duration.
    issue(1'b0, 0);
    n = 0;
    while (busy8 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, 8);

    issue(1'b0, 144);
    issue(1'b0, 145);
    issue(1'b0, 99);
    issue(1'b0, 65535);

    // Starts during CALC are ignored; next start in the done cycle is accepted.
    issue(1'b0, 200);
    @(negedge clk); start8 = 1'b1; rad8 = 16'd50;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    issue(1'b0, 50);
    n = 0;
    while (busy8 && n < 50) begin
      n++;
      @(negedge clk);
    end

    // Reset asserted mid-computation.
    issue(1'b0, 40000);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_root8", longint'(root8), 0);
    chk("abort_rem8", longint'(rem8), 0);
    chk("abort_busy8", longint'(busy8), 0);
    chk("abort_done8", longint'(done8), 0);
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(1'b0, 1);

    // Random N=8 with varying gaps.
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'b0, longint'($urandom_range(0, 65535)));
    end

    // Random N=16, including the extremes.
    issue(1'b1, 0);
    issue(1'b1, 64'hFFFF_FFFF);
    for (int i = 0; i < 500; i++) begin
      v = longint'($urandom);
      issue(1'b1, v);
    end

    n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("drain", q8.size() + q16.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
